maindec_mc: RTL and testbench
=============================

// Module: maindec_mc
// PURPOSE
//  Multicycle successor to the single-cycle main decoder: a Moore control FSM that sequences
//  each instruction over 3-5 cycles. Adds JR, an explicit illegal-opcode trap and a memory
//  ready handshake for variable-latency memory. Sits in the multicycle CPU controller,
//  driving the datapath muxes/enables; the ALU decoder consumes aluop and funct as before.
// PARAMETERS
//  OPW       6         opcode width; encodings below are zero-extended to OPW
//  FW        6         funct width
//  HANDSHAKE 1         1: memory states wait on mem_ready; 0: mem_ready treated as 1
//  FUNCT_JR  6'b001000 funct code that selects JR when op==R-type
// PORTS
//  clk       in  1    rising-edge clock
//  reset     in  1    synchronous, active-high
//  op        in  OPW  instruction opcode (valid from DECODE onward, held by IR)
//  funct     in  FW   instruction funct field
//  mem_ready in  1    memory access completes this cycle
//  pcwrite   out 1    PC load enable
//  branch    out 1    conditional PC load (ANDed with zero outside)
//  iord      out 1    0: PC addresses memory, 1: ALUOut addresses memory
//  memwrite  out 1    memory write strobe
//  irwrite   out 1    instruction register load
//  regdst    out 2    00 rt, 01 rd, 10 r31
//  memtoreg  out 2    00 ALUOut, 01 MDR, 10 PC (link)
//  regwrite  out 1    register file write
//  alusrca   out 1    0 PC, 1 A
//  alusrcb   out 2    00 B, 01 const 4, 10 signimm, 11 signimm<<2
//  aluop     out 2    00 add, 01 sub, 10 use funct
//  pcsrc     out 2    00 ALU, 01 ALUOut, 10 jump target, 11 A (JR)
//  state     out 4    current state encoding (debug/verification)
//  illegal   out 1    sticky illegal-opcode flag
// BEHAVIOUR
//  Opcodes: R 000000, LW 000001, SW 000010, ADDI 000011, SUBI 000100, BEQ 000101,
//   J 000111, JAL 001000. JR = R with funct==FUNCT_JR. Anything else is illegal.
//  Outputs are pure functions of state; any output not listed for a state is 0.
//  States and transitions (rdy = mem_ready | ~HANDSHAKE):
//   0 FETCH : iord=0 alusrcb=01 aluop=00 pcsrc=00; irwrite=pcwrite=rdy; rdy ? DECODE : FETCH
//   1 DECODE: alusrcb=11 aluop=00; ->MEMADR(LW,SW) EXEC(R) JR(R&JR) BRANCH IMMEX JUMP JAL, else ILLEGAL
//   2 MEMADR: alusrca=1 alusrcb=10; ->MEMRD (LW) / MEMWR (SW)
//   3 MEMRD : iord=1; rdy ? MEMWB : MEMRD
//   4 MEMWB : regdst=00 memtoreg=01 regwrite=1 ->FETCH
//   5 MEMWR : iord=1 memwrite=1 (held until rdy); rdy ? FETCH : MEMWR
//   6 EXEC  : alusrca=1 alusrcb=00 aluop=10 ->ALUWB
//   7 ALUWB : regdst=01 memtoreg=00 regwrite=1 ->FETCH
//   8 BRANCH: alusrca=1 aluop=01 pcsrc=01 branch=1 ->FETCH
//   9 IMMEX : alusrca=1 alusrcb=10 aluop=00 (ADDI) / 01 (SUBI) ->IMMWB
//  10 IMMWB : regdst=00 memtoreg=00 regwrite=1 ->FETCH
//  11 JUMP  : pcsrc=10 pcwrite=1 ->FETCH
//  12 JAL   : pcsrc=10 pcwrite=1 regdst=10 memtoreg=10 regwrite=1 ->FETCH
//  13 JR    : pcsrc=11 pcwrite=1 ->FETCH
//  15 ILLEGAL: illegal=1, all enables 0; stays until reset. 14 unused -> FETCH next cycle.
//  Cycle counts (rdy=1): BEQ/J/JAL/JR 3, R/SW/ADDI/SUBI 4, LW 5; each rdy=0 cycle adds one.
//  Reset: state<=FETCH, illegal<=0 on the clk edge with reset=1; while reset=1, pcwrite,
//   irwrite, memwrite, regwrite and branch are forced 0 regardless of state; reset overrides
//   any in-flight state including mid-MEMWR/MEMRD wait and ILLEGAL.
//  op/funct are sampled only in DECODE and IMMEX; changes elsewhere have no effect.
// TESTING
//  reset 2 cycles, LW op=000001, rdy=1 -> states 0,1,2,3,4,0; MEMWB memtoreg=01 regwrite=1
//  SW op=000010, mem_ready low 3 cycles in MEMWR -> memwrite=1 for 4 cycles, then FETCH
//  R op=000000 funct=100000 -> 0,1,6,7; aluop=10 in EXEC; funct=001000 -> 0,1,13 pcsrc=11
//  JAL op=001000 -> state 12: pcwrite=1 regwrite=1 regdst=10 memtoreg=10; BEQ -> branch=1 pcsrc=01
//  op=101010 -> state 15, illegal=1 held 10 cycles, enables 0; reset -> FETCH, illegal=0
//  HANDSHAKE=0, mem_ready=0 tied: ADDI op=000011 completes in 4 cycles, SUBI aluop=01 in IMMEX

Source files
------------

// File: rtl/maindec_mc.sv
// ---------------------------------------------------------------------------
// maindec_mc
//   Moore control FSM for the multicycle CPU. Each instruction runs through
//   FETCH and DECODE, then one to three execution states (memory states may
//   stretch while memory is not ready), and returns to FETCH. Unknown opcodes
//   trap into a sticky ILLEGAL state that only reset leaves.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high; also gates all write enables
//   op         in   [OPW-1:0] opcode from the instruction register
//   funct      in   [FW-1:0]  funct field from the instruction register
//   mem_ready  in   memory access completes this cycle
//   pcwrite    out  PC load enable
//   branch     out  conditional PC load (qualified by zero outside)
//   iord       out  memory address select: 0 PC, 1 ALUOut
//   memwrite   out  memory write strobe
//   irwrite    out  instruction register load
//   regdst     out  [1:0] write register: 00 rt, 01 rd, 10 r31
//   memtoreg   out  [1:0] write data: 00 ALUOut, 01 MDR, 10 PC
//   regwrite   out  register file write enable
//   alusrca    out  ALU A: 0 PC, 1 A
//   alusrcb    out  [1:0] ALU B: 00 B, 01 4, 10 signimm, 11 signimm<<2
//   aluop      out  [1:0] 00 add, 01 sub, 10 decode funct
//   pcsrc      out  [1:0] PC source: 00 ALU, 01 ALUOut, 10 jump, 11 A
//   state      out  [3:0] current state (debug / verification)
//   illegal    out  sticky illegal-opcode flag
// ---------------------------------------------------------------------------
module maindec_mc #(
   parameter int              OPW       = 6,
   parameter int              FW        = 6,
   parameter bit              HANDSHAKE = 1'b1,
   parameter logic [FW-1:0]   FUNCT_JR  = 6'b001000
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [OPW-1:0] op,
   input  logic [FW-1:0]  funct,
   input  logic           mem_ready,
   output logic           pcwrite,
   output logic           branch,
   output logic           iord,
   output logic           memwrite,
   output logic           irwrite,
   output logic [1:0]     regdst,
   output logic [1:0]     memtoreg,
   output logic           regwrite,
   output logic           alusrca,
   output logic [1:0]     alusrcb,
   output logic [1:0]     aluop,
   output logic [1:0]     pcsrc,
   output logic [3:0]     state,
   output logic           illegal
);

   localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
   localparam logic [OPW-1:0] OP_LW   = OPW'(6'b000001);
   localparam logic [OPW-1:0] OP_SW   = OPW'(6'b000010);
   localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b000011);
   localparam logic [OPW-1:0] OP_SUBI = OPW'(6'b000100);
   localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000101);
   localparam logic [OPW-1:0] OP_J    = OPW'(6'b000111);
   localparam logic [OPW-1:0] OP_JAL  = OPW'(6'b001000);

   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADR  = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_EXEC    = 4'd6;
   localparam logic [3:0] S_ALUWB   = 4'd7;
   localparam logic [3:0] S_BRANCH  = 4'd8;
   localparam logic [3:0] S_IMMEX   = 4'd9;
   localparam logic [3:0] S_IMMWB   = 4'd10;
   localparam logic [3:0] S_JUMP    = 4'd11;
   localparam logic [3:0] S_JAL     = 4'd12;
   localparam logic [3:0] S_JR      = 4'd13;
   localparam logic [3:0] S_ILLEGAL = 4'd15;

   logic       rdy;
   logic [3:0] state_next;
   logic       is_store;
   logic       illegal_r;

   // Without the handshake, memory is assumed to complete every cycle.
   assign rdy = mem_ready | ~HANDSHAKE;

   always_comb begin
      state_next = state;
      case (state)
         S_FETCH:   state_next = rdy ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW:     state_next = S_MEMADR;
               OP_R:             state_next = (funct == FUNCT_JR) ? S_JR : S_EXEC;
               OP_BEQ:           state_next = S_BRANCH;
               OP_ADDI, OP_SUBI: state_next = S_IMMEX;
               OP_J:             state_next = S_JUMP;
               OP_JAL:           state_next = S_JAL;
               default:          state_next = S_ILLEGAL;
            endcase
         end
         S_MEMADR:  state_next = is_store ? S_MEMWR : S_MEMRD;
         S_MEMRD:   state_next = rdy ? S_MEMWB : S_MEMRD;
         S_MEMWR:   state_next = rdy ? S_FETCH : S_MEMWR;
         S_EXEC:    state_next = S_ALUWB;
         S_IMMEX:   state_next = S_IMMWB;
         S_ILLEGAL: state_next = S_ILLEGAL;
         default:   state_next = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_FETCH;
         illegal_r <= 1'b0;
      end else begin
         state <= state_next;
         if (state_next == S_ILLEGAL)
            illegal_r <= 1'b1;
      end
   end

   // The load/store choice is taken from the opcode while it is decoded, so
   // the IR may change afterwards without redirecting MEMADR.
   always_ff @(posedge clk) begin
      if (state == S_DECODE)
         is_store <= (op == OP_SW);
   end

   assign illegal = illegal_r;

   always_comb begin
      pcwrite  = 1'b0;
      branch   = 1'b0;
      iord     = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regdst   = 2'b00;
      memtoreg = 2'b00;
      regwrite = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      aluop    = 2'b00;
      pcsrc    = 2'b00;
      case (state)
         S_FETCH: begin
            alusrcb = 2'b01;
            irwrite = rdy;
            pcwrite = rdy;
         end
         S_DECODE: alusrcb = 2'b11;
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD:  iord = 1'b1;
         S_MEMWB: begin
            memtoreg = 2'b01;
            regwrite = 1'b1;
         end
         S_MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         S_EXEC: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
         end
         S_ALUWB: begin
            regdst   = 2'b01;
            regwrite = 1'b1;
         end
         S_BRANCH: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            pcsrc   = 2'b01;
            branch  = 1'b1;
         end
         S_IMMEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            aluop   = (op == OP_SUBI) ? 2'b01 : 2'b00;
         end
         S_IMMWB:  regwrite = 1'b1;
         S_JUMP: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         S_JAL: begin
            pcsrc    = 2'b10;
            pcwrite  = 1'b1;
            regdst   = 2'b10;
            memtoreg = 2'b10;
            regwrite = 1'b1;
         end
         S_JR: begin
            pcsrc   = 2'b11;
            pcwrite = 1'b1;
         end
         default: ;
      endcase
      // Keep every architectural write quiet while reset is asserted,
      // whatever state the machine happens to be in.
      if (reset) begin
         pcwrite  = 1'b0;
         irwrite  = 1'b0;
         memwrite = 1'b0;
         regwrite = 1'b0;
         branch   = 1'b0;
      end
   end

endmodule

// File: tb/tb_maindec_mc.sv
`timescale 1ns/1ps
module tb_maindec_mc;

   typedef struct packed {
      logic       pcwrite;
      logic       branch;
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic [1:0] regdst;
      logic [1:0] memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsrc;
      logic [3:0] state;
      logic       illegal;
   } out_t;

   typedef struct packed {
      logic [5:0]      op;
      logic [5:0]      fn;
      logic [2:0]      len;
      logic [4:0][3:0] st;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1, mem_ready = 1'b1;
   logic [5:0] op = '0, funct = '0;
   logic       reset1 = 1'b1, mem_ready1 = 1'b0;
   logic [5:0] op1 = '0, funct1 = '0;

   logic a_pcw, a_br, a_iord, a_mw, a_irw, a_rw, a_asa, a_ill;
   logic [1:0] a_rd, a_mtr, a_asb, a_aop, a_pcs;
   logic [3:0] a_st;
   logic b_pcw, b_br, b_iord, b_mw, b_irw, b_rw, b_asa, b_ill;
   logic [1:0] b_rd, b_mtr, b_asb, b_aop, b_pcs;
   logic [3:0] b_st;
   out_t obs0, obs1;

   assign obs0 = {a_pcw, a_br, a_iord, a_mw, a_irw, a_rd, a_mtr, a_rw, a_asa, a_asb, a_aop, a_pcs, a_st, a_ill};
   assign obs1 = {b_pcw, b_br, b_iord, b_mw, b_irw, b_rd, b_mtr, b_rw, b_asa, b_asb, b_aop, b_pcs, b_st, b_ill};

   maindec_mc dut0 (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
      .pcwrite(a_pcw), .branch(a_br), .iord(a_iord), .memwrite(a_mw), .irwrite(a_irw),
      .regdst(a_rd), .memtoreg(a_mtr), .regwrite(a_rw), .alusrca(a_asa), .alusrcb(a_asb),
      .aluop(a_aop), .pcsrc(a_pcs), .state(a_st), .illegal(a_ill)
   );

   maindec_mc #(.HANDSHAKE(1'b0)) dut1 (
      .clk(clk), .reset(reset1), .op(op1), .funct(funct1), .mem_ready(mem_ready1),
      .pcwrite(b_pcw), .branch(b_br), .iord(b_iord), .memwrite(b_mw), .irwrite(b_irw),
      .regdst(b_rd), .memtoreg(b_mtr), .regwrite(b_rw), .alusrca(b_asa), .alusrcb(b_asb),
      .aluop(b_aop), .pcsrc(b_pcs), .state(b_st), .illegal(b_ill)
   );

   int n_pass = 0, n_total = 0;
   int cur_state = 0;

   // Expected outputs for a given state, straight from the per-state table.
   function automatic out_t model_out(input int st, input bit rdy, input logic [5:0] o, input bit rst);
      out_t m;
      m = '0;
      m.state = 4'(st);
      case (st)
         0:  begin m.alusrcb = 2'b01; m.irwrite = rdy; m.pcwrite = rdy; end
         1:  m.alusrcb = 2'b11;
         2:  begin m.alusrca = 1; m.alusrcb = 2'b10; end
         3:  m.iord = 1;
         4:  begin m.memtoreg = 2'b01; m.regwrite = 1; end
         5:  begin m.iord = 1; m.memwrite = 1; end
         6:  begin m.alusrca = 1; m.aluop = 2'b10; end
         7:  begin m.regdst = 2'b01; m.regwrite = 1; end
         8:  begin m.alusrca = 1; m.aluop = 2'b01; m.pcsrc = 2'b01; m.branch = 1; end
         9:  begin m.alusrca = 1; m.alusrcb = 2'b10; m.aluop = (o == 6'b000100) ? 2'b01 : 2'b00; end
         10: m.regwrite = 1;
         11: begin m.pcsrc = 2'b10; m.pcwrite = 1; end
         12: begin m.pcsrc = 2'b10; m.pcwrite = 1; m.regdst = 2'b10; m.memtoreg = 2'b10; m.regwrite = 1; end
         13: begin m.pcsrc = 2'b11; m.pcwrite = 1; end
         15: m.illegal = 1;
         default: ;
      endcase
      if (rst) begin
         m.pcwrite = 0; m.irwrite = 0; m.memwrite = 0; m.regwrite = 0; m.branch = 0;
      end
      return m;
   endfunction

   task automatic check(input string name, input out_t act, input out_t exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got state=%0d vec=%h, required state=%0d vec=%h",
                    name, act.state, act, exp.state, exp);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, exp);
   endtask

   // One cycle on dut0: drive at negedge, compare 1ns later.
   task automatic step0(input string name, input int st, input bit rdy, input logic [5:0] o, input logic [5:0] f);
      @(negedge clk);
      reset = 0; mem_ready = rdy; op = o; funct = f;
      #1 check(name, obs0, model_out(st, rdy, o, 0));
   endtask

   task automatic step1(input string name, input int st, input logic [5:0] o);
      @(negedge clk);
      reset1 = 0; mem_ready1 = 0; op1 = o; funct1 = 6'b100000;
      #1 check(name, obs1, model_out(st, 1'b1, o, 0));
   endtask

   task automatic do_reset(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         reset = 1; mem_ready = 1'($urandom); op = 6'($urandom);
         #1 check("reset", obs0, model_out((i == 0) ? cur_state : 0, mem_ready, op, 1));
      end
      cur_state = 0;
   endtask

   // Random instruction: expected state path derived from the instruction
   // class, with random memory wait cycles and garbage on op/funct wherever
   // the decoder is not supposed to look at them.
   task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn, input int maxw);
      int body[$];
      int ss[$];
      bit rr[$];
      int w;
      logic [5:0] o, f;
      case (iop)
         6'b000001: body = '{2, 3, 4};
         6'b000010: body = '{2, 5};
         6'b000000: if (ifn == 6'b001000) body = '{13}; else body = '{6, 7};
         6'b000011, 6'b000100: body = '{9, 10};
         6'b000101: body = '{8};
         6'b000111: body = '{11};
         6'b001000: body = '{12};
         default:   body = '{15, 15, 15};
      endcase
      w = $urandom_range(maxw, 0);
      repeat (w) begin ss.push_back(0); rr.push_back(0); end
      ss.push_back(0); rr.push_back(1);
      ss.push_back(1); rr.push_back(1'($urandom));
      foreach (body[k]) begin
         if (body[k] == 3 || body[k] == 5) begin
            w = $urandom_range(maxw, 0);
            repeat (w) begin ss.push_back(body[k]); rr.push_back(0); end
            ss.push_back(body[k]); rr.push_back(1);
         end else begin
            ss.push_back(body[k]); rr.push_back(1'($urandom));
         end
      end
      foreach (ss[k]) begin
         o = (ss[k] == 1 || ss[k] == 9) ? iop : 6'($urandom);
         f = (ss[k] == 1) ? ifn : 6'($urandom);
         step0("random", ss[k], rr[k], o, f);
      end
      cur_state = (body[0] == 15) ? 15 : 0;
   endtask

   function automatic vec_t mk(input logic [5:0] o, input logic [5:0] f, input int n,
                               input int s2, input int s3, input int s4);
      vec_t v;
      v.op = o; v.fn = f; v.len = 3'(n);
      v.st[0] = 4'd0; v.st[1] = 4'd1;
      v.st[2] = 4'(s2); v.st[3] = 4'(s3); v.st[4] = 4'(s4);
      return v;
   endfunction

   vec_t vecs[10];
   logic [5:0] legal_ops[8];

   initial begin
      int cnt;
      logic [5:0] ro, rf;
      vecs[0] = mk(6'b000001, 6'b000000, 5, 2, 3, 4);   // LW
      vecs[1] = mk(6'b000010, 6'b000000, 4, 2, 5, 0);   // SW
      vecs[2] = mk(6'b000000, 6'b100000, 4, 6, 7, 0);   // R add
      vecs[3] = mk(6'b000000, 6'b001000, 3, 13, 0, 0);  // JR
      vecs[4] = mk(6'b000101, 6'b000000, 3, 8, 0, 0);   // BEQ
      vecs[5] = mk(6'b000011, 6'b000000, 4, 9, 10, 0);  // ADDI
      vecs[6] = mk(6'b000100, 6'b000000, 4, 9, 10, 0);  // SUBI
      vecs[7] = mk(6'b000111, 6'b000000, 3, 11, 0, 0);  // J
      vecs[8] = mk(6'b001000, 6'b000000, 3, 12, 0, 0);  // JAL
      vecs[9] = mk(6'b000000, 6'b101010, 4, 6, 7, 0);   // R slt
      legal_ops = '{6'b000000, 6'b000001, 6'b000010, 6'b000011,
                    6'b000100, 6'b000101, 6'b000111, 6'b001000};

      do_reset(2);

      // Table-driven instruction paths with memory always ready.
      foreach (vecs[k]) begin
         for (int i = 0; i < int'(vecs[k].len); i++)
            step0("vector", int'(vecs[k].st[i]), 1'b1, vecs[k].op, vecs[k].fn);
      end

      // SW with memory stalled three cycles in MEMWR.
      cnt = 0;
      step0("sw_wait", 0, 1, 6'b000010, 0);
      step0("sw_wait", 1, 1, 6'b000010, 0);
      step0("sw_wait", 2, 1, 6'b000010, 0);
      for (int i = 0; i < 4; i++) begin
         step0("sw_wait", 5, (i == 3), 6'b000010, 0);
         cnt += int'(obs0.memwrite);
      end
      check_int("sw_memwrite_cycles", cnt, 4);
      step0("sw_done", 0, 1, 6'b000010, 0);

      // Reset while stalled in MEMWR.
      step0("sw_rst", 1, 1, 6'b000010, 0);
      step0("sw_rst", 2, 1, 6'b000010, 0);
      step0("sw_rst", 5, 0, 6'b000010, 0);
      cur_state = 5;
      do_reset(2);

      // Illegal opcode trap: held until reset.
      step0("illegal", 0, 1, 6'b101010, 0);
      step0("illegal", 1, 1, 6'b101010, 0);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step0("illegal_hold", 15, 1'($urandom), 6'($urandom), 6'($urandom));
         cnt += int'(obs0.illegal);
      end
      check_int("illegal_cycles", cnt, 10);
      cur_state = 15;
      do_reset(1);
      step0("after_illegal", 0, 0, 6'b000000, 0);

      // Randomized instruction stream against the path model.
      for (int n = 0; n < 150; n++) begin
         int r;
         r = $urandom_range(39, 0);
         if (r == 0) ro = 6'b100000 | 6'($urandom_range(31, 0));
         else ro = legal_ops[r % 8];
         rf = ($urandom_range(3, 0) == 0) ? 6'b001000 : 6'($urandom);
         run_instr(ro, rf, 2);
         if (cur_state == 15) do_reset($urandom_range(2, 1));
      end

      // HANDSHAKE disabled, mem_ready tied low.
      step1("hs0_addi", 0, 6'b000011);
      step1("hs0_addi", 1, 6'b000011);
      step1("hs0_addi", 9, 6'b000011);
      step1("hs0_addi", 10, 6'b000011);
      step1("hs0_subi", 0, 6'b000100);
      step1("hs0_subi", 1, 6'b000100);
      step1("hs0_subi", 9, 6'b000100);
      check_int("hs0_subi_aluop", int'(obs1.aluop), 1);
      step1("hs0_subi", 10, 6'b000100);
      step1("hs0_lw", 0, 6'b000001);
      step1("hs0_lw", 1, 6'b000001);
      step1("hs0_lw", 2, 6'b000001);
      step1("hs0_lw", 3, 6'b000001);
      step1("hs0_lw", 4, 6'b000001);
      step1("hs0_lw", 0, 6'b000001);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
